tictactoe_game_ctrl: RTL
========================

// Module: tictactoe_game_ctrl
// PURPOSE
//  Game sequencer for the 3x3 TicTacToe board.
//  - Holds board state and takes alternating moves from the player-input logic.
//  - After every legal move, time-multiplexes ONE shared WinnerDetector3 instance over the 8 lines.
//  - Reports win/draw to the display logic.
// PARAMETERS
//  FIRST_PLAYER  2'b01  cell code of the player who moves first after reset/new_game (01 or 10 only)
// PORTS
//  clk         in   1   system clock; all state changes on rising edge
//  reset       in   1   synchronous, active-high; highest priority
//  new_game    in   1   1-cycle pulse: clear board, restart game
//  move_valid  in   1   move request from current player
//  move_pos    in   4   target cell 0..8 (row-major, cell0 top-left)
//  move_ready  out  1   controller can accept a move this cycle
//  move_err    out  1   1-cycle pulse: request rejected (pos>8 or cell occupied)
//  board       out  18  cell i at board[2i+1:2i]; 00 empty, 01 P1, 10 P2
//  turn        out  2   player to move (01/10)
//  game_over   out  1   game finished, level until reset/new_game
//  winner      out  2   winning player code; 00 if no winner yet or draw
//  draw        out  1   board full, no winner; level until reset/new_game
// BEHAVIOUR
//  Reset (sync, active-high):
//   - board=0, turn=FIRST_PLAYER, move_count=0, state=WAIT.
//   - game_over=0, winner=00, draw=0, move_err=0, move_ready=1 from the next cycle.
//  new_game = same effect as reset, lower priority than reset, accepted in any state.
//   - A move_valid in the same cycle is dropped: no write, no move_err.
//  Handshake:
//   - move_ready = (state==WAIT) && !new_game. A move is taken on move_valid && move_ready.
//   - move_valid while move_ready=0 is ignored: no error, no queueing.
//  FSM states WAIT, SCAN, DONE:
//   - WAIT, illegal request: move_err=1 next cycle. Board, turn and state unchanged.
//   - WAIT, legal request: write turn into cell, move_count++, line_idx=0, go to SCAN.
//   - SCAN: the detector inputs are the 3 cells of LINE_TABLE[line_idx], selected combinationally from the already-updated board.
//   - SCAN, winner=1: latch winner<=who, game_over<=1, go to DONE.
//   - SCAN, no win and line_idx<7: line_idx++.
//   - SCAN, no win and line_idx==7, move_count==9: draw<=1, game_over<=1, go to DONE.
//   - SCAN, no win and line_idx==7, move_count<9: toggle turn (01<->10), go to WAIT.
//   - DONE: hold all outputs. Only reset/new_game leave DONE.
//  LINE_TABLE order:
//   - 0:{0,1,2} 1:{3,4,5} 2:{6,7,8} 3:{0,3,6}
//   - 4:{1,4,7} 5:{2,5,8} 6:{0,4,8} 7:{2,4,6}
//  Latency, move accepted in cycle T:
//   - SCAN line k runs in cycle T+1+k.
//   - First win on line k: game_over/winner visible from T+2+k.
//   - No win: turn toggled and move_ready=1 at T+9.
//   - Draw: draw=1 at T+9.
//  Edge rules:
//   - Scan stops at the first hit, so a move completing two lines reports once.
//   - Winning on the 9th move is a win, not a draw.
//   - Cell code 11 is never written.
//   - move_pos 9..15 is always rejected.
//   - line_idx is 3 bits; no wrap (SCAN exits at 7).
//   - reset/new_game mid-SCAN aborts the scan and discards its result.
// STRUCTURE
//  Package tictactoe_pkg holds:
//   - cell_t enum (EMPTY=2'b00, P1=2'b01, P2=2'b10)
//   - ctrl_state_t enum (WAIT, SCAN, DONE)
//   - NUM_CELLS=9, NUM_LINES=8
//   - LINE_TABLE constant: 8 x 3 x 4-bit cell indices
//  Sub-module: exactly one existing WinnerDetector3, instantiated once and shared. No new sub-module.
// TESTING
//  - Reset: after reset, board=0, turn=01, move_ready=1, game_over=0, winner=00, draw=0.
//  - Row win: P1 plays 0, P2 3, P1 1, P2 4, P1 2.
//    -> after the 5th move, game_over=1 and winner=01 two cycles later (line 0 hit). move_ready stays 0.
//  - Illegal moves: move_pos=4 twice, then move_pos=12.
//    -> 2nd and 3rd requests each give a move_err 1-cycle pulse; board unchanged; turn stays 10.
//  - Draw: sequence 0,1,2,4,3,5,7,6,8.
//    -> 9 cycles after the last move, draw=1, game_over=1, winner=00.
//  - Diagonal win by P2 on line 7 ({2,4,6}): winner=10 nine cycles after the move.
//    Verify turn toggles at T+9 on each non-winning move.
//  - Abort: new_game pulsed during SCAN with move_valid=1.
//    -> board cleared next cycle, no win latched, move dropped, turn=FIRST_PLAYER.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the TicTacoe game sequencer: cell codes,
// controller states and the fixed order in which the 8 winning lines are scanned.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    // Rows, then columns, then the two diagonals; scan order decides which
    // line is reported when one move completes several.
    localparam logic [3:0] LINE_TABLE [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/WinnerDetector3.sv
// Combinational check of one 3-cell line: flags a win when all three cells
// hold the same non-empty player code and reports that code.
module WinnerDetector3 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] c,
    output logic       winner,
    output logic [1:0] who
);

    always_comb begin
        winner = (a != 2'b00) && (a == b) && (b == c);
        who    = winner ? a : 2'b00;
    end

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// TicTacToe game sequencer: accepts alternating moves, then walks one shared
// line detector over the 8 lines to decide win, draw or next turn.
module tictactoe_game_ctrl
    import tictactoe_pkg::*;
#(
    parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [3:0]  move_pos,
    output logic        move_ready,
    output logic        move_err,
    output logic [17:0] board,
    output logic [1:0]  turn,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic        draw
);

    // Handshake: a move is consumed in the cycle where move_valid and
    // move_ready are both high; move_valid without move_ready is ignored.

    ctrl_state_t state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [1:0]  turn_q, turn_d;
    logic [3:0]  count_q, count_d;
    logic [2:0]  line_q, line_d;
    logic [1:0]  winner_q, winner_d;
    logic        game_over_q, game_over_d;
    logic        draw_q, draw_d;
    logic        err_q, err_d;

    logic [1:0]  target_cell;
    logic        legal;
    logic        take;
    logic [1:0]  det_a, det_b, det_c;
    logic        det_win;
    logic [1:0]  det_who;

    assign move_ready = (state_q == WAIT) && !new_game;
    assign take       = move_valid && move_ready;

    // Cell lookups use explicit compares so out-of-range positions never index the board.
    always_comb begin
        target_cell = 2'b00;
        det_a       = 2'b00;
        det_b       = 2'b00;
        det_c       = 2'b00;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (move_pos == 4'(i))              target_cell = board_q[2*i +: 2];
            if (LINE_TABLE[line_q][0] == 4'(i)) det_a = board_q[2*i +: 2];
            if (LINE_TABLE[line_q][1] == 4'(i)) det_b = board_q[2*i +: 2];
            if (LINE_TABLE[line_q][2] == 4'(i)) det_c = board_q[2*i +: 2];
        end
    end

    assign legal = (move_pos < 4'(NUM_CELLS)) && (target_cell == EMPTY);

    WinnerDetector3 u_detector (
        .a      (det_a),
        .b      (det_b),
        .c      (det_c),
        .winner (det_win),
        .who    (det_who)
    );

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        turn_d      = turn_q;
        count_d     = count_q;
        line_d      = line_q;
        winner_d    = winner_q;
        game_over_d = game_over_q;
        draw_d      = draw_q;
        err_d       = 1'b0;

        if (new_game) begin
            state_d     = WAIT;
            board_d     = '0;
            turn_d      = FIRST_PLAYER;
            count_d     = '0;
            line_d      = '0;
            winner_d    = EMPTY;
            game_over_d = 1'b0;
            draw_d      = 1'b0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (take) begin
                        if (legal) begin
                            for (int i = 0; i < NUM_CELLS; i++) begin
                                if (move_pos == 4'(i)) board_d[2*i +: 2] = turn_q;
                            end
                            count_d = count_q + 4'd1;
                            line_d  = '0;
                            state_d = SCAN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (det_win) begin
                        winner_d    = det_who;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else if (line_q != 3'(NUM_LINES - 1)) begin
                        line_d = line_q + 3'd1;
                    end else if (count_q == 4'(NUM_CELLS)) begin
                        draw_d      = 1'b1;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        turn_d  = other_player(turn_q);
                        state_d = WAIT;
                    end
                end
                DONE: begin
                end
                default: state_d = WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT;
            board_q     <= '0;
            turn_q      <= FIRST_PLAYER;
            count_q     <= '0;
            line_q      <= '0;
            winner_q    <= 2'b00;
            game_over_q <= 1'b0;
            draw_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            turn_q      <= turn_d;
            count_q     <= count_d;
            line_q      <= line_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
            draw_q      <= draw_d;
            err_q       <= err_d;
        end
    end

    assign board     = board_q;
    assign turn      = turn_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign draw      = draw_q;
    assign move_err  = err_q;

endmodule
